// File: rtl/imm_decode_stage_pkg.sv
// -----------------------------------------------------------------------------
// imm_decode_stage_pkg
// Shared definitions for the immediate decode stage:
//   - fmt_e       : immediate format code reported on fmt_o
//   - OP_*        : RV base opcodes that carry an immediate
//   - F3_*        : OP-IMM funct3 values that select a shift-amount immediate
//   - xlen_legal(): elaboration-time legality check for the XLEN parameter
// -----------------------------------------------------------------------------
package imm_decode_stage_pkg;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_SHAMT = 3'd2,
    FMT_S     = 3'd3,
    FMT_B     = 3'd4,
    FMT_U     = 3'd5,
    FMT_J     = 3'd6
  } fmt_e;

  localparam logic [6:0] OP_LUI       = 7'b0110111;
  localparam logic [6:0] OP_AUIPC     = 7'b0010111;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP_IMM_32 = 7'b0011011;

  // Shift-left-logical and shift-right (logical/arithmetic) in OP-IMM space.
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  function automatic bit xlen_legal(input int unsigned xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_decode_stage_imm_extract.sv
// -----------------------------------------------------------------------------
// imm_extract
// Purely combinational immediate extractor for one 32-bit instruction word.
// Ports:
//   inst_i    in  32    instruction word to decode
//   imm_o     out XLEN  sign/zero-extended immediate
//   fmt_o     out 3     immediate format (fmt_e)
//   illegal_o out 1     opcode has no immediate-bearing encoding
// Parameters:
//   XLEN      32 or 64
//   ILLEGAL_X 1: imm_o is all-X for illegal opcodes, 0: imm_o is zero
// -----------------------------------------------------------------------------
module imm_extract
  import imm_decode_stage_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter bit          ILLEGAL_X = 1'b0
) (
  input  logic [31:0]     inst_i,
  output logic [XLEN-1:0] imm_o,
  output fmt_e            fmt_o,
  output logic            illegal_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_shift;

  assign opcode   = inst_i[6:0];
  assign funct3   = inst_i[14:12];
  assign is_shift = (funct3 == F3_SLL) || (funct3 == F3_SR);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned; an unassigned path would infer a latch.
    imm_o     = '0;
    fmt_o     = FMT_NONE;
    illegal_o = 1'b0;

    unique case (opcode)
      OP_LUI, OP_AUIPC: begin
        fmt_o = FMT_U;
        imm_o = XLEN'($signed({inst_i[31:12], 12'b0}));
      end
      OP_JAL: begin
        fmt_o = FMT_J;
        imm_o = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20],
                               inst_i[30:21], 1'b0}));
      end
      OP_BRANCH: begin
        fmt_o = FMT_B;
        imm_o = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25],
                               inst_i[11:8], 1'b0}));
      end
      OP_STORE: begin
        fmt_o = FMT_S;
        imm_o = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
      end
      OP_JALR, OP_LOAD: begin
        fmt_o = FMT_I;
        imm_o = XLEN'($signed(inst_i[31:20]));
      end
      OP_OP_IMM: begin
        if (is_shift) begin
          // RV64 shifts use a 6-bit shamt; inst[25] is part of the funct7
          // field on RV32 and must not leak into the immediate there.
          fmt_o = FMT_SHAMT;
          imm_o = (XLEN == 64) ? XLEN'(inst_i[25:20]) : XLEN'(inst_i[24:20]);
        end else begin
          fmt_o = FMT_I;
          imm_o = XLEN'($signed(inst_i[31:20]));
        end
      end
      OP_OP_IMM_32: begin
        // The *W word ops exist only on RV64 and always shift by 5 bits.
        if (XLEN == 64) begin
          if (is_shift) begin
            fmt_o = FMT_SHAMT;
            imm_o = XLEN'(inst_i[24:20]);
          end else begin
            fmt_o = FMT_I;
            imm_o = XLEN'($signed(inst_i[31:20]));
          end
        end else begin
          illegal_o = 1'b1;
          imm_o     = ILLEGAL_X ? {XLEN{1'bx}} : '0;
        end
      end
      default: begin
        illegal_o = 1'b1;
        imm_o     = ILLEGAL_X ? {XLEN{1'bx}} : '0;
      end
    endcase
  end

endmodule

// File: rtl/imm_decode_stage.sv
// -----------------------------------------------------------------------------
// imm_decode_stage
// One-cycle pipeline stage that extracts the immediate of an RV instruction.
// An output register holds the decoded result; a one-entry skid register
// absorbs the instruction accepted in the cycle the output stalls, so the
// registered in_ready_o never depends combinationally on out_ready_i.
// Ports:
//   clk          in  1     rising-edge clock
//   rst          in  1     synchronous active-high reset
//   in_valid_i   in  1     upstream instruction valid
//   in_ready_o   out 1     stage can accept (registered, equals skid empty)
//   inst_i       in  32    raw instruction word
//   pc_i         in  XLEN  instruction PC
//   out_valid_o  out 1     decoded result valid
//   out_ready_i  in  1     downstream accepts result
//   imm_o        out XLEN  extended immediate
//   fmt_o        out 3     format code (fmt_e encoding)
//   illegal_o    out 1     opcode has no immediate-bearing encoding
//   pc_o         out XLEN  PC of the instruction on the output
//   inst_o       out 32    instruction word on the output
// -----------------------------------------------------------------------------
module imm_decode_stage
  import imm_decode_stage_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter bit          ILLEGAL_X = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      fmt_o,
  output logic            illegal_o,
  output logic [XLEN-1:0] pc_o,
  output logic [31:0]     inst_o
);

  if (!xlen_legal(XLEN)) begin : g_bad_xlen
    $error("imm_decode_stage: XLEN must be 32 or 64");
  end

  // Output register.
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] imm_q,       imm_d;
  fmt_e            fmt_q,       fmt_d;
  logic            illegal_q,   illegal_d;
  logic [XLEN-1:0] pc_q,        pc_d;
  logic [31:0]     inst_q,      inst_d;

  // Skid register holds the raw word; it is decoded when it moves forward.
  logic            skid_valid_q, skid_valid_d;
  logic [31:0]     skid_inst_q,  skid_inst_d;
  logic [XLEN-1:0] skid_pc_q,    skid_pc_d;

  logic            in_ready_q,   in_ready_d;

  // Decoder source: the skid entry is older than anything on the input.
  logic [31:0]     src_inst;
  logic [XLEN-1:0] src_pc;
  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  logic            dec_illegal;

  logic            in_fire;
  logic            out_free;
  logic            load_out;

  assign src_inst = skid_valid_q ? skid_inst_q : inst_i;
  assign src_pc   = skid_valid_q ? skid_pc_q   : pc_i;

  imm_extract #(
    .XLEN      (XLEN),
    .ILLEGAL_X (ILLEGAL_X)
  ) u_imm_extract (
    .inst_i    (src_inst),
    .imm_o     (dec_imm),
    .fmt_o     (dec_fmt),
    .illegal_o (dec_illegal)
  );

  always_comb begin
    out_valid_d  = out_valid_q;
    imm_d        = imm_q;
    fmt_d        = fmt_q;
    illegal_d    = illegal_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    skid_valid_d = skid_valid_q;
    skid_inst_d  = skid_inst_q;
    skid_pc_d    = skid_pc_q;
    load_out     = 1'b0;

    in_fire  = in_valid_i && in_ready_q;
    // Output register may take a new entry when empty or draining this edge.
    out_free = !out_valid_q || out_ready_i;

    if (skid_valid_q) begin
      // in_ready_q is low here, so no new input can arrive this cycle.
      if (out_free) begin
        load_out     = 1'b1;
        skid_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      if (out_free) begin
        load_out = 1'b1;
      end else begin
        skid_valid_d = 1'b1;
        skid_inst_d  = inst_i;
        skid_pc_d    = pc_i;
      end
    end

    if (load_out) begin
      out_valid_d = 1'b1;
      imm_d       = dec_imm;
      fmt_d       = dec_fmt;
      illegal_d   = dec_illegal;
      pc_d        = src_pc;
      inst_d      = src_inst;
    end else if (out_valid_q && out_ready_i) begin
      out_valid_d = 1'b0;
    end

    in_ready_d = !skid_valid_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      imm_q        <= '0;
      fmt_q        <= FMT_NONE;
      illegal_q    <= 1'b0;
      pc_q         <= '0;
      inst_q       <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      imm_q        <= imm_d;
      fmt_q        <= fmt_d;
      illegal_q    <= illegal_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  // NOTE: skid payload is qualified by skid_valid_q, so it carries no reset.
  always_ff @(posedge clk) begin
    skid_inst_q <= skid_inst_d;
    skid_pc_q   <= skid_pc_d;
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign imm_o       = imm_q;
  assign fmt_o       = fmt_q;
  assign illegal_o   = illegal_q;
  assign pc_o        = pc_q;
  assign inst_o      = inst_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_imm_decode_stage
// Self-checking bench for imm_decode_stage (XLEN=32, ILLEGAL_X=0).
// A queue holds the instructions the stage should contain, in order; the
// expected immediate of each is computed from the RISC-V field layout with
// plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_imm_decode_stage;
  import imm_decode_stage_pkg::*;

  localparam int unsigned XLEN = 32;

  logic            clk;
  logic            rst;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [31:0]     inst_i;
  logic [XLEN-1:0] pc_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] imm_o;
  logic [2:0]      fmt_o;
  logic            illegal_o;
  logic [XLEN-1:0] pc_o;
  logic [31:0]     inst_o;

  imm_decode_stage #(
    .XLEN      (XLEN),
    .ILLEGAL_X (1'b0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .inst_i      (inst_i),
    .pc_i        (pc_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .imm_o       (imm_o),
    .fmt_o       (fmt_o),
    .illegal_o   (illegal_o),
    .pc_o        (pc_o),
    .inst_o      (inst_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        illegal;
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t model_q[$];

  // Interpret the low 'bits' bits of v as two's complement.
  function automatic logic [31:0] sext(input longint v, input int bits);
    longint r = v;
    if (r >= (longint'(1) << (bits - 1))) r = r - (longint'(1) << bits);
    return 32'(r);
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] inst, input logic [31:0] pc);
    exp_t   e;
    longint w   = longint'(inst);
    longint opc = w % 128;
    longint f3  = (w / 4096) % 8;
    longint v;
    e.pc = pc; e.inst = inst; e.imm = '0; e.fmt = FMT_NONE; e.illegal = 1'b0;
    case (opc)
      'h37, 'h17: begin
        e.fmt = FMT_U;
        e.imm = 32'((w / 4096) * 4096);
      end
      'h6F: begin
        v = ((w >> 31) & 1) * (1 << 20) + ((w >> 12) & 'hFF) * (1 << 12)
          + ((w >> 20) & 1) * (1 << 11) + ((w >> 21) & 'h3FF) * 2;
        e.fmt = FMT_J; e.imm = sext(v, 21);
      end
      'h63: begin
        v = ((w >> 31) & 1) * (1 << 12) + ((w >> 7) & 1) * (1 << 11)
          + ((w >> 25) & 'h3F) * 32 + ((w >> 8) & 'hF) * 2;
        e.fmt = FMT_B; e.imm = sext(v, 13);
      end
      'h23: begin
        v = ((w >> 25) & 'h7F) * 32 + ((w >> 7) & 'h1F);
        e.fmt = FMT_S; e.imm = sext(v, 12);
      end
      'h67, 'h03: begin
        e.fmt = FMT_I; e.imm = sext(w >> 20, 12);
      end
      'h13: begin
        if (f3 == 1 || f3 == 5) begin
          e.fmt = FMT_SHAMT; e.imm = 32'((w >> 20) & 'h1F);
        end else begin
          e.fmt = FMT_I; e.imm = sext(w >> 20, 12);
        end
      end
      default: e.illegal = 1'b1;
    endcase
    return e;
  endfunction

  // Drive one cycle of stimulus, compare outputs against the model, then
  // advance the model by the handshakes that occur at the coming edge.
  task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic rdy);
    bit in_fire, out_fire;
    in_valid_i  = v;
    inst_i      = inst;
    pc_i        = pc;
    out_ready_i = rdy;
    @(negedge clk);
    check("out_valid", 64'(out_valid_o), 64'(model_q.size() > 0));
    check("in_ready",  64'(in_ready_o),  64'(model_q.size() < 2));
    if (model_q.size() > 0) begin
      check("imm",     64'(imm_o),     64'(model_q[0].imm));
      check("fmt",     64'(fmt_o),     64'(model_q[0].fmt));
      check("illegal", 64'(illegal_o), 64'(model_q[0].illegal));
      check("pc",      64'(pc_o),      64'(model_q[0].pc));
      check("inst",    64'(inst_o),    64'(model_q[0].inst));
    end
    in_fire  = v && (model_q.size() < 2);
    out_fire = rdy && (model_q.size() > 0);
    if (out_fire) void'(model_q.pop_front());
    if (in_fire)  model_q.push_back(ref_decode(inst, pc));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 1'b1);
  endtask

  // Single instruction into an empty stage; result checked one cycle later.
  task automatic directed(input string tag, input logic [31:0] inst,
                          input logic [31:0] exp_imm, input logic [2:0] exp_fmt,
                          input logic exp_ill);
    step(1'b1, inst, 32'h0000_1000, 1'b1);
    in_valid_i = 1'b0;
    check({tag, "_valid"},   64'(out_valid_o), 64'(1));
    check({tag, "_imm"},     64'(imm_o),       64'(exp_imm));
    check({tag, "_fmt"},     64'(fmt_o),       64'(exp_fmt));
    check({tag, "_illegal"}, 64'(illegal_o),   64'(exp_ill));
    drain();
  endtask

  task automatic apply_reset();
    rst        = 1'b1;
    in_valid_i = 1'b1;   // must be ignored while rst is high
    inst_i     = 32'h0000_0013;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    in_valid_i = 1'b0;
    model_q.delete();
    check("rst_out_valid", 64'(out_valid_o), 64'(0));
    check("rst_in_ready",  64'(in_ready_o),  64'(1));
    check("rst_imm",       64'(imm_o),       64'(0));
    check("rst_fmt",       64'(fmt_o),       64'(FMT_NONE));
    check("rst_illegal",   64'(illegal_o),   64'(0));
    check("rst_pc",        64'(pc_o),        64'(0));
    check("rst_inst",      64'(inst_o),      64'(0));
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0]  opcodes [12] = '{7'h37, 7'h17, 7'h6F, 7'h63, 7'h23, 7'h67,
                                  7'h03, 7'h13, 7'h13, 7'h3B, 7'h0F, 7'h00};
    logic [31:0] r   = $urandom();
    logic [6:0]  opc = opcodes[$urandom_range(0, 11)];
    if ($urandom_range(0, 9) == 0) opc = r[6:0];
    return {r[31:7], opc};
  endfunction

  initial begin
    rst         = 1'b1;
    in_valid_i  = 1'b0;
    inst_i      = '0;
    pc_i        = '0;
    out_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    apply_reset();

    directed("lui",  32'h1234_5037, 32'h1234_5000, FMT_U,     1'b0);
    directed("jal",  32'hFFDF_F06F, 32'hFFFF_FFFC, FMT_J,     1'b0);
    directed("sw",   32'hFE20_AE23, 32'hFFFF_FFFC, FMT_S,     1'b0);
    directed("srai", 32'h4030_D093, 32'h0000_0003, FMT_SHAMT, 1'b0);
    directed("fence",32'h0000_000F, 32'h0000_0000, FMT_NONE,  1'b1);
    directed("addiw",32'h0010_809B, 32'h0000_0000, FMT_NONE,  1'b1);

    // Stalled output: three back-to-back offers, only two are taken.
    step(1'b1, 32'h0010_0093, 32'h100, 1'b0);
    step(1'b1, 32'h0020_0113, 32'h104, 1'b0);
    step(1'b1, 32'h0030_0193, 32'h108, 1'b0);
    check("stall_in_ready", 64'(in_ready_o), 64'(0));
    drain();

    // Random traffic with random back-pressure.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, rand_inst(), $urandom(), $urandom_range(0, 3) != 0);
    end
    drain();

    // Reset while both registers are occupied.
    step(1'b1, 32'h0000_0537, 32'h200, 1'b0);
    step(1'b1, 32'h0000_0597, 32'h204, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0);
    check("full_in_ready", 64'(in_ready_o), 64'(0));
    apply_reset();
    step(1'b0, 32'h0, 32'h0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
